// File: rtl/fpu_arb_pkg.sv
// ============================================================================
//  Module      : fpu_arb_pkg
//  Description : Shared types and constants for the FPU request arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [31:0] RSP_ERR_DATA = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker; search starts at last+1.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any
);

    logic [ID_W:0] w_idx;

    // Walk from the farthest candidate to the nearest so the nearest set bit wins.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        w_idx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = {1'b0, last} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(N_REQ);
            end
            if (req[w_idx[ID_W-1:0]]) begin
                gnt                    = '0;
                gnt[w_idx[ID_W-1:0]]   = 1'b1;
                gnt_id                 = w_idx[ID_W-1:0];
                any                    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fpu_arbiter.sv
// ============================================================================
//  Module      : fpu_arbiter
//  Description : Shares one IEEE754 ALU among N_REQ requesters, one op at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_arbiter
    import fpu_arb_pkg::*;
#(
    parameter  int N_REQ   = 4,
    parameter  int TIMEOUT = 1000,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [N_REQ-1:0]     req_vld,
    output logic [N_REQ-1:0]     req_rdy,
    input  logic [N_REQ*32-1:0]  req_a,
    input  logic [N_REQ*32-1:0]  req_b,
    input  logic [N_REQ*2-1:0]   req_op,
    output logic [31:0]          alu_data1,
    output logic [31:0]          alu_data2,
    output logic [1:0]           alu_opcode,
    output logic                 alu_trig,
    input  logic [31:0]          alu_data_out,
    input  logic                 alu_vld,
    input  logic                 alu_work,
    output logic                 rsp_vld,
    output logic [ID_W-1:0]      rsp_id,
    output logic [31:0]          rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic [N_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]   w_gnt_id;
    logic              w_any;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req    (req_vld),
        .last   (last_q),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id),
        .any    (w_any)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            last_q     <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            cnt_q      <= '0;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            id_q       <= id_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        id_d       = id_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        req_rdy    = '0;
        alu_trig   = 1'b0;
        alu_data1  = '0;
        alu_data2  = '0;
        alu_opcode = '0;
        case (state_q)
            ST_IDLE: begin
                if (!alu_work) begin
                    req_rdy = w_gnt;
                    if (w_any) begin
                        id_d    = w_gnt_id;
                        last_d  = w_gnt_id;
                        a_d     = req_a[{w_gnt_id, 5'd0} +: 32];
                        b_d     = req_b[{w_gnt_id, 5'd0} +: 32];
                        op_d    = req_op[{w_gnt_id, 1'b0} +: 2];
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                alu_trig   = 1'b1;
                alu_data1  = a_q;
                alu_data2  = b_q;
                alu_opcode = op_q;
                cnt_d      = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A result landing on the final timeout cycle still counts as good.
                if (alu_vld) begin
                    rsp_id_d   = id_q;
                    rsp_data_d = alu_data_out;
                    rsp_err_d  = 1'b0;
                    state_d    = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_id_d   = id_q;
                    rsp_data_d = RSP_ERR_DATA;
                    rsp_err_d  = 1'b1;
                    state_d    = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rsp_vld  = (state_q == ST_RESP);
    assign busy     = (state_q != ST_IDLE);
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
// ============================================================================
//  Module      : tb_fpu_arbiter
//  Description : Randomised and directed bench for fpu_arbiter with ALU stub.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_arbiter;
    import fpu_arb_pkg::*;

    localparam int N    = 4;
    localparam int TO   = 20;
    localparam int NOPS = 10000;

    logic              sys_clk = 1'b0;
    logic              sys_rst;
    logic [N-1:0]      req_vld, req_rdy;
    logic [N*32-1:0]   req_a, req_b;
    logic [N*2-1:0]    req_op;
    logic [31:0]       alu_data1, alu_data2, alu_data_out, rsp_data;
    logic [1:0]        alu_opcode, rsp_id;
    logic              alu_trig, alu_vld, alu_work, rsp_vld, rsp_err, busy;

    fpu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) u_dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_op       (req_op),
        .alu_data1    (alu_data1),
        .alu_data2    (alu_data2),
        .alu_opcode   (alu_opcode),
        .alu_trig     (alu_trig),
        .alu_data_out (alu_data_out),
        .alu_vld      (alu_vld),
        .alu_work     (alu_work),
        .rsp_vld      (rsp_vld),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // single-precision arithmetic via exact widening to double, then RNE narrowing
    function automatic logic [63:0] f2d(input logic [31:0] f);
        if (f[30:0] == 31'd0) return {f[31], 63'd0};
        return {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        logic [10:0] e;
        logic [31:0] r;
        e = d[62:52];
        if (e == 11'h7FF) return (d[51:0] != 0) ? 32'hFFFF_FFFF : {d[63], 8'hFF, 23'd0};
        if (e == 11'd0) return {d[63], 31'd0};
        r = {1'b0, 8'(e - 11'd896), d[51:29]};
        if (d[28] && ((d[27:0] != 0) || d[29])) r = r + 32'd1;
        return {d[63], r[30:0]};
    endfunction

    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
        real ra, rb;
        ra = $bitstoreal(f2d(a));
        rb = $bitstoreal(f2d(b));
        case (op)
            OP_ADD:  return d2f($realtobits(ra + rb));
            OP_SUB:  return d2f($realtobits(ra - rb));
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)};
    endfunction

    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
        logic [N-1:0] one;
        one = 1;
        for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return one << ((last + k) % N);
        return '0;
    endfunction

    // ALU stub
    int          alu_lat  = 1;
    bit          alu_mute = 0;
    bit          alu_rand = 0;
    int          alu_cd   = 0;
    logic [31:0] alu_res;

    initial begin
        alu_vld = 1'b0;
        alu_data_out = '0;
        forever begin
            @(posedge sys_clk); #1;
            alu_vld = 1'b0;
            if (alu_cd > 0) begin
                alu_cd--;
                if (alu_cd == 0) begin
                    alu_vld = 1'b1;
                    alu_data_out = alu_res;
                end
            end
            if (alu_trig === 1'b1) begin
                if (alu_mute) alu_cd = 0;
                else begin
                    alu_cd  = alu_rand ? int'($urandom_range(1, 2)) : alu_lat;
                    alu_res = alu_fn(alu_data1, alu_data2, alu_opcode);
                end
            end
        end
    end

    // reference model and monitor
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_acc = 0, m_rsp = -1, m_id = 0, m_last = N - 1;
    logic [31:0] m_a, m_b, m_data;
    logic [1:0]  m_op;
    bit          m_err;
    int          acc_log[$];
    int          last_acc_cyc = 0, last_rsp_cyc = 0, n_rsp = 0;

    initial begin
        bit r;
        bit ev;
        bit et;
        logic [N-1:0] er;
        forever begin
            @(posedge sys_clk);
            cyc++;
            r = sys_rst;
            @(negedge sys_clk);
            if (r) begin
                m_busy = 0;
                m_last = N - 1;
                m_rsp  = -1;
            end
            check("busy", busy, m_busy);
            er = (!m_busy && !alu_work) ? rr_pick(req_vld, m_last) : '0;
            check("req_rdy", req_rdy, er);
            et = m_busy && (cyc == m_acc + 1);
            check("alu_trig", alu_trig, et);
            if (et) begin
                check("alu_data1", alu_data1, m_a);
                check("alu_data2", alu_data2, m_b);
                check("alu_opcode", alu_opcode, m_op);
                if (alu_mute || alu_cd > TO) begin
                    m_rsp = m_acc + 2 + TO; m_data = 32'hFFFF_FFFF; m_err = 1;
                end else begin
                    m_rsp = m_acc + 2 + alu_cd; m_data = alu_fn(m_a, m_b, m_op); m_err = 0;
                end
            end else begin
                check("alu_idle_ops", {alu_data1, alu_data2[29:0], alu_opcode}, 64'd0);
            end
            ev = m_busy && (cyc == m_rsp);
            check("rsp_vld", rsp_vld, ev);
            if (ev) begin
                check("rsp_id", rsp_id, m_id);
                check("rsp_data", rsp_data, m_data);
                check("rsp_err", rsp_err, m_err);
                m_busy = 0;
                n_rsp++;
                last_rsp_cyc = cyc;
            end
            if (!sys_rst && ((er & req_vld) != 0)) begin
                for (int i = 0; i < N; i++) if (er[i]) m_id = i;
                m_busy = 1;
                m_last = m_id;
                m_acc  = cyc;
                m_rsp  = -1;
                m_a    = req_a[32*m_id +: 32];
                m_b    = req_b[32*m_id +: 32];
                m_op   = req_op[2*m_id +: 2];
                acc_log.push_back(m_id);
                last_acc_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk); #1;
    endtask

    task automatic wait_acc(input int n);
        int k = 0;
        while (acc_log.size() < n && k < 300) begin tick(); k++; end
        check("wait_accept", acc_log.size() >= n, 1);
    endtask

    task automatic wait_rsp(input int n);
        int k = 0;
        while (n_rsp < n && k < TO + 300) begin tick(); k++; end
        check("wait_response", n_rsp >= n, 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < TO + 300) begin tick(); k++; end
        check("wait_idle", busy, 0);
    endtask

    task automatic do_reset();
        tick(); sys_rst = 1;
        tick(); sys_rst = 0;
    endtask

    initial begin
        int base;
        int ncnt;
        sys_rst = 1; req_vld = '0; req_a = '0; req_b = '0; req_op = '0; alu_work = 0;
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 0;
        check("rst_rsp_id", rsp_id, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_vld", rsp_vld, 0);

        // single request, L=5
        alu_lat = 5;
        req_a[31:0] = 32'h3F80_0000; req_b[31:0] = 32'h4000_0000; req_op[1:0] = OP_ADD;
        req_vld = 4'b0001;
        wait_acc(1);
        req_vld = '0;
        wait_rsp(1);
        check("single_data", rsp_data, 32'h4040_0000);
        check("single_lat", last_rsp_cyc - last_acc_cyc, 7);
        check("single_id", rsp_id, 0);

        // contention from reset
        do_reset();
        alu_lat = 2;
        base = acc_log.size();
        req_vld = 4'b1111;
        wait_acc(base + 5);
        req_vld = '0;
        for (int i = 0; i < 5; i++) check("rr_order", acc_log[base + i], i % 4);
        wait_idle();

        // timeout
        alu_mute = 1;
        ncnt = n_rsp;
        req_vld = 4'b0001;
        wait_acc(acc_log.size() + 1);
        req_vld = '0;
        wait_rsp(ncnt + 1);
        check("to_lat", last_rsp_cyc - last_acc_cyc, TO + 2);
        check("to_err", rsp_err, 1);
        check("to_data", rsp_data, 32'hFFFF_FFFF);
        alu_mute = 0;

        // result arrives on the last timeout cycle
        alu_lat = TO;
        ncnt = n_rsp;
        req_vld = 4'b0001;
        wait_acc(acc_log.size() + 1);
        req_vld = '0;
        wait_rsp(ncnt + 1);
        check("tie_err", rsp_err, 0);
        check("tie_data", rsp_data, 32'h4040_0000);
        check("tie_lat", last_rsp_cyc - last_acc_cyc, TO + 2);

        // reset while waiting, late alu_vld
        do_reset();
        alu_lat = 6;
        req_a[63:32] = rnd_fp(); req_b[63:32] = rnd_fp(); req_op[3:2] = OP_SUB;
        req_vld = 4'b0010;
        wait_acc(acc_log.size() + 1);
        req_vld = '0;
        check("rw_first_id", acc_log[$], 1);
        ncnt = n_rsp;
        tick(); tick(); tick(); sys_rst = 1;
        tick(); sys_rst = 0;
        repeat (8) tick();
        check("rw_no_rsp", n_rsp, ncnt);
        req_vld = 4'b1111;
        wait_acc(acc_log.size() + 1);
        req_vld = '0;
        check("rw_next_id", acc_log[$], 0);
        wait_idle();

        // alu_work holds off the accept
        alu_lat = 1;
        alu_work = 1;
        req_a[95:64] = rnd_fp(); req_b[95:64] = rnd_fp(); req_op[5:4] = OP_ADD;
        req_vld = 4'b0100;
        base = acc_log.size();
        repeat (5) tick();
        check("aw_no_accept", acc_log.size(), base);
        alu_work = 0;
        ncnt = cyc;
        wait_acc(base + 1);
        req_vld = '0;
        check("aw_accept_cyc", last_acc_cyc, ncnt);
        check("aw_accept_id", acc_log[$], 2);
        wait_idle();

        // random regression
        alu_rand = 1;
        ncnt = n_rsp;
        for (int c = 0; c < 70000 && (n_rsp - ncnt) < NOPS; c++) begin
            tick();
            req_vld = N'($urandom);
            for (int i = 0; i < N; i++) begin
                req_a[32*i +: 32] = rnd_fp();
                req_b[32*i +: 32] = rnd_fp();
                req_op[2*i +: 2]  = 2'($urandom_range(0, 1));
            end
            alu_work = ($urandom_range(0, 7) == 0);
        end
        req_vld = '0;
        alu_work = 0;
        check("rand_ops", n_rsp - ncnt >= NOPS, 1);
        wait_idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/fpu_arbiter.md
FPU_ARBITER -- requirements
Module: fpu_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one IEEE754 ALU (2..8).
REQ-002 Parameter TIMEOUT, default 1000, maximum cycles in WAIT before abort; must be >= 1.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset. Ports are listed as name, direction, width, meaning.
REQ-004 sys_clk  in  1  single clock; all logic on rising edge.
REQ-005 sys_rst  in  1  synchronous reset, active-high.
REQ-006 req_vld  in  N_REQ  per-requester operation request.
REQ-007 req_rdy  out  N_REQ  one-hot accept; a request is taken when req_vld[i] and req_rdy[i] are both high in a cycle.
REQ-008 req_a, req_b  in  N_REQ*32  per-requester operands, packed; slice i is [32*i+:32].
REQ-009 req_op  in  N_REQ*2  per-requester opcode: 0 add, 1 sub, 2 mul, 3 div.
REQ-010 alu_data1, alu_data2  out  32  ALU operands.
REQ-011 alu_opcode  out  2  ALU opcode.
REQ-012 alu_trig  out  1  one-cycle ALU start.
REQ-013 alu_data_out  in  32  ALU result.
REQ-014 alu_vld  in  1  ALU result valid.
REQ-015 alu_work  in  1  ALU busy.
REQ-016 rsp_vld  out  1  one-cycle response strobe; no backpressure.
REQ-017 rsp_id  out  $clog2(N_REQ)  index of the requester that owns the response.
REQ-018 rsp_data  out  32  result.
REQ-019 rsp_err  out  1  timeout flag.
REQ-020 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-021 The FSM SHALL have four states (IDLE, ISSUE, WAIT, RESP) with these transitions:
  - IDLE->ISSUE on accept.
  - ISSUE->WAIT unconditionally.
  - WAIT->RESP on alu_vld or timeout.
  - RESP->IDLE unconditionally.
REQ-022 In IDLE with alu_work=0, req_rdy SHALL be combinationally one-hot on the round-robin winner among req_vld. The search starts at last_grant+1 modulo N_REQ.
REQ-023 req_rdy SHALL be all-zero outside IDLE, while alu_work=1, and when no req_vld bit is set.
REQ-024 On accept, the block SHALL latch a, b, op and id of the winner, and set last_grant to that id.
REQ-025 In ISSUE, the block SHALL drive alu_trig=1 with the latched operands and opcode. In every other state, alu_trig, alu_data1, alu_data2 and alu_opcode SHALL be 0.
REQ-026 In WAIT, a counter starts at 0 and increments each cycle.
  - alu_vld=1 SHALL capture alu_data_out with rsp_err=0.
  - When the counter reaches TIMEOUT-1 with alu_vld=0, the block SHALL set rsp_data=32'hFFFF_FFFF and rsp_err=1.
  - If both happen in the same cycle, alu_vld SHALL win.
REQ-027 alu_vld SHALL be ignored outside WAIT, including in the ISSUE cycle.
REQ-028 In RESP, rsp_vld SHALL be 1 for exactly one cycle, with rsp_id, rsp_data and rsp_err registered. These outputs hold their last values after the strobe.
REQ-029 Latency SHALL be: accept at cycle T, alu_trig at T+1, alu_vld at T+1+L (L>=1), rsp_vld at T+2+L. The earliest next accept is T+3+L.
REQ-030 A requester that drops req_vld before accept SHALL lose nothing. Its request is simply not taken.
REQ-031 Changes to req_a, req_b and req_op after accept SHALL NOT affect the operation in flight.
REQ-032 At most one operation SHALL be outstanding at a time.

Reset
REQ-033 sys_rst=1 at any clock edge SHALL force: state IDLE; last_grant=N_REQ-1, so requester 0 has first priority; counter 0.
REQ-034 Reset SHALL clear all outputs to 0, except req_rdy, which follows REQ-022 from the cycle after reset deasserts.
REQ-035 Reset mid-operation SHALL abandon the operation with no rsp_vld. A late alu_vld SHALL be ignored per REQ-027.

Structure
REQ-036 Package fpu_arb_pkg SHALL hold:
  - the state enum;
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - constant RSP_ERR_DATA = 32'hFFFF_FFFF.
REQ-037 Round-robin selection SHALL be a sub-module rr_arbiter with ports:
  - inputs req[N_REQ], last[$clog2(N_REQ)];
  - outputs gnt one-hot, gnt_id, any.

Verification
REQ-038 Single request: req0 add, a=0x3F800000, b=0x40000000; ALU model L=5 -> trig at T+1, rsp_vld at T+7, rsp_id=0, rsp_data=0x40400000, rsp_err=0.
REQ-039 Contention: all four req_vld held high from reset -> accept order 0,1,2,3,0; each rsp_id matches its accepted index.
REQ-040 Timeout: ALU model never asserts alu_vld -> rsp_vld exactly TIMEOUT+1 cycles after trig, rsp_err=1, rsp_data=0xFFFFFFFF.
REQ-041 Reset in WAIT: sys_rst pulsed 3 cycles after trig, then ALU asserts alu_vld -> no rsp_vld; next accept goes to requester 0.
REQ-042 alu_work=1 in IDLE with req2 pending -> req_rdy=0 every cycle; the accept happens the first cycle alu_work=0.
REQ-043 Random regression: 1e4 random add/sub ops on random requesters; rsp_data matches the shortreal reference, with NaN results normalised to 0xFFFFFFFF.
